param_num_combiner: RTL and testbench

PARAM_NUM_COMBINER -- requirements
Module: param_num_combiner

---
 rtl/param_num_combiner.sv | 155 +++++++++++++++
 tb/tb_param_num_combiner.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_num_combiner.sv
// Two-stage multi-channel combiner: each channel reduces one shared operand set
// (A, B, C) using its own fixed mode, with optional saturation and mode-3 accumulators.
module param_num_combiner #(
    parameter int unsigned                P_WIDTH    = 16,
    parameter int unsigned                P_CHANNELS = 2,
    parameter logic [2*P_CHANNELS-1:0]    P_MODES    = {2'd1, 2'd0},
    parameter bit                         P_SAT      = 1'b0
) (
    input  logic                             ib_clk,
    input  logic                             ib_rst,
    input  logic                             ib_in_valid,
    output logic                             ob_in_ready,
    input  logic [P_WIDTH-1:0]               iv_numA,
    input  logic [P_WIDTH-1:0]               iv_numB,
    input  logic [P_WIDTH-1:0]               iv_numC,
    input  logic                             ib_acc_clr,
    output logic                             ob_out_valid,
    input  logic                             ib_out_ready,
    output logic [P_CHANNELS*P_WIDTH-1:0]    ov_num,
    output logic [P_CHANNELS-1:0]            ov_ovf
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // Valid never waits on ready, and data/valid hold until their transfer completes.
    // A stage loads when it is empty or when its contents leave in the same cycle.

    logic s1_valid;
    logic s2_valid;
    logic s1_load;
    logic s2_load;
    logic [P_WIDTH-1:0] s1_c;

    assign ob_in_ready  = !s1_valid | (!s2_valid | ib_out_ready);
    assign ob_out_valid = s2_valid;
    assign s1_load      = ib_in_valid & ob_in_ready;
    assign s2_load      = s1_valid & (!s2_valid | ib_out_ready);

    always_ff @(posedge ib_clk or posedge ib_rst) begin
        if (ib_rst) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge ib_clk or posedge ib_rst) begin
        if (ib_rst) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
        end else if (ib_out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // C is common to every channel, so one copy travels with the stage-1 valid bit.
    always_ff @(posedge ib_clk or posedge ib_rst) begin
        if (ib_rst) begin
            s1_c <= '0;
        end else if (s1_load) begin
            s1_c <= iv_numC;
        end
    end

    for (genvar k = 0; k < P_CHANNELS; k++) begin : g_ch
        localparam logic [1:0] MODE = P_MODES[2*k +: 2];

        logic [P_WIDTH:0]   part_d;
        logic [P_WIDTH:0]   part_q;
        logic [P_WIDTH-1:0] acc_base;
        logic [P_WIDTH+1:0] exact;
        logic               neg;
        logic               over;
        logic [P_WIDTH-1:0] res;
        logic [P_WIDTH-1:0] num_q;
        logic               ovf_q;

        always_comb begin
            part_d = '0;
            if (MODE == 2'd2) begin
                part_d = (iv_numA > iv_numB) ? {1'b0, iv_numA} : {1'b0, iv_numB};
            end else begin
                part_d = {1'b0, iv_numA} + {1'b0, iv_numB};
            end
        end

        always_ff @(posedge ib_clk or posedge ib_rst) begin
            if (ib_rst) begin
                part_q <= '0;
            end else if (s1_load) begin
                part_q <= part_d;
            end
        end

        // Only mode-3 channels own an accumulator; a clear coinciding with a
        // load means the loaded set starts a fresh sum.
        if (MODE == 2'd3) begin : g_acc
            logic [P_WIDTH-1:0] acc_q;

            always_ff @(posedge ib_clk or posedge ib_rst) begin
                if (ib_rst) begin
                    acc_q <= '0;
                end else if (s2_load) begin
                    acc_q <= res;
                end else if (ib_acc_clr) begin
                    acc_q <= '0;
                end
            end

            assign acc_base = ib_acc_clr ? '0 : acc_q;
        end else begin : g_no_acc
            assign acc_base = '0;
        end

        // P_WIDTH+2 bits hold every exact result; mode 1 is the only one that can go negative.
        always_comb begin
            exact = '0;
            case (MODE)
                2'd1:    exact = {1'b0, part_q} - {2'b00, s1_c};
                2'd2:    exact = {1'b0, part_q} + {2'b00, s1_c};
                default: exact = {1'b0, part_q} + {2'b00, s1_c} + {2'b00, acc_base};
            endcase
        end

        assign neg  = (MODE == 2'd1) && exact[P_WIDTH+1];
        assign over = !neg && (exact[P_WIDTH+1:P_WIDTH] != 2'b00);

        always_comb begin
            res = exact[P_WIDTH-1:0];
            if (P_SAT) begin
                if (neg) begin
                    res = '0;
                end else if (over) begin
                    res = '1;
                end
            end
        end

        always_ff @(posedge ib_clk or posedge ib_rst) begin
            if (ib_rst) begin
                num_q <= '0;
                ovf_q <= 1'b0;
            end else if (s2_load) begin
                num_q <= res;
                ovf_q <= ovf_q | neg | over;
            end
        end

        assign ov_num[k*P_WIDTH +: P_WIDTH] = num_q;
        assign ov_ovf[k]                    = ovf_q;
    end

endmodule

// File: tb/tb_param_num_combiner.sv
// Self-checking bench for param_num_combiner: four configurations share one
// handshake stream and are checked against a scoreboard fed by a reference model.
module tb_param_num_combiner;

    localparam int          NI        = 4;
    localparam int          EW        = 264;
    localparam logic [15:0] BIG_MODES = 16'hB4E1;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic acc_clr;
    logic out_ready;
    logic [31:0] a32, b32, c32;

    logic [31:0]  def_num;
    logic [1:0]   def_ovf;
    logic         def_in_ready, def_out_valid;
    logic [63:0]  w4_num;
    logic [3:0]   w4_ovf;
    logic         w4_in_ready, w4_out_valid;
    logic [63:0]  s4_num;
    logic [3:0]   s4_ovf;
    logic         s4_in_ready, s4_out_valid;
    logic [255:0] big_num;
    logic [7:0]   big_ovf;
    logic         big_in_ready, big_out_valid;

    int n_cmp = 0;
    int n_mis = 0;
    bit was_stalled = 1'b0;
    bit xfer = 1'b0;

    logic [EW*NI-1:0] exp_q[$];
    longint           acc_m [NI][8];
    logic [7:0]       sticky_m [NI];

    always #5 clk = ~clk;

    param_num_combiner u_def (
        .ib_clk(clk), .ib_rst(rst), .ib_in_valid(in_valid), .ob_in_ready(def_in_ready),
        .iv_numA(a32[15:0]), .iv_numB(b32[15:0]), .iv_numC(c32[15:0]), .ib_acc_clr(acc_clr),
        .ob_out_valid(def_out_valid), .ib_out_ready(out_ready), .ov_num(def_num), .ov_ovf(def_ovf)
    );

    param_num_combiner #(.P_WIDTH(16), .P_CHANNELS(4), .P_MODES(8'b11_10_01_00), .P_SAT(1'b0)) u_w4 (
        .ib_clk(clk), .ib_rst(rst), .ib_in_valid(in_valid), .ob_in_ready(w4_in_ready),
        .iv_numA(a32[15:0]), .iv_numB(b32[15:0]), .iv_numC(c32[15:0]), .ib_acc_clr(acc_clr),
        .ob_out_valid(w4_out_valid), .ib_out_ready(out_ready), .ov_num(w4_num), .ov_ovf(w4_ovf)
    );

    param_num_combiner #(.P_WIDTH(16), .P_CHANNELS(4), .P_MODES(8'b11_10_01_00), .P_SAT(1'b1)) u_s4 (
        .ib_clk(clk), .ib_rst(rst), .ib_in_valid(in_valid), .ob_in_ready(s4_in_ready),
        .iv_numA(a32[15:0]), .iv_numB(b32[15:0]), .iv_numC(c32[15:0]), .ib_acc_clr(acc_clr),
        .ob_out_valid(s4_out_valid), .ib_out_ready(out_ready), .ov_num(s4_num), .ov_ovf(s4_ovf)
    );

    param_num_combiner #(.P_WIDTH(32), .P_CHANNELS(8), .P_MODES(BIG_MODES), .P_SAT(1'b0)) u_big (
        .ib_clk(clk), .ib_rst(rst), .ib_in_valid(in_valid), .ob_in_ready(big_in_ready),
        .iv_numA(a32), .iv_numB(b32), .iv_numC(c32), .ib_acc_clr(acc_clr),
        .ob_out_valid(big_out_valid), .ib_out_ready(out_ready), .ov_num(big_num), .ov_ovf(big_ovf)
    );

    function automatic int inst_w(input int i);
        return (i == 3) ? 32 : 16;
    endfunction

    function automatic int inst_ch(input int i);
        return (i == 0) ? 2 : (i == 3) ? 8 : 4;
    endfunction

    function automatic logic [15:0] inst_modes(input int i);
        return (i == 0) ? 16'h0004 : (i == 3) ? BIG_MODES : 16'h00E4;
    endfunction

    function automatic bit inst_sat(input int i);
        return (i == 2);
    endfunction

    function automatic logic [EW-1:0] obs(input int i);
        case (i)
            0:       return {6'b0, def_ovf, 224'b0, def_num};
            1:       return {4'b0, w4_ovf, 192'b0, w4_num};
            2:       return {4'b0, s4_ovf, 192'b0, s4_num};
            default: return {big_ovf, big_num};
        endcase
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact signed arithmetic, then clamp or truncate.
    task automatic model_ch(input int w, input logic [1:0] mode, input bit sat, input bit clr,
                            input longint a, input longint b, input longint c,
                            inout longint acc, output longint res, output bit ovf);
        longint maxv;
        longint ex;
        maxv = (longint'(1) << w) - 1;
        case (mode)
            2'd0:    ex = a + b + c;
            2'd1:    ex = a + b - c;
            2'd2:    ex = ((a > b) ? a : b) + c;
            default: ex = (clr ? 0 : acc) + a + b + c;
        endcase
        ovf = (ex < 0) || (ex > maxv);
        if (sat) res = (ex < 0) ? 0 : (ex > maxv) ? maxv : ex;
        else     res = ex & maxv;
        if (mode == 2'd3) acc = res;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input bit clr);
        logic [EW*NI-1:0] e;
        logic [255:0]     num;
        logic [15:0]      modes;
        longint           mask;
        longint           res;
        bit               ovf;
        e = '0;
        for (int i = 0; i < NI; i++) begin
            num   = '0;
            modes = inst_modes(i);
            mask  = (longint'(1) << inst_w(i)) - 1;
            for (int k = 0; k < inst_ch(i); k++) begin
                model_ch(inst_w(i), modes[2*k +: 2], inst_sat(i), clr,
                         longint'(a) & mask, longint'(b) & mask, longint'(c) & mask,
                         acc_m[i][k], res, ovf);
                num = num | (256'(res) << (k * inst_w(i)));
                if (ovf) sticky_m[i][k] = 1'b1;
            end
            e[i*EW +: EW] = {sticky_m[i], num};
        end
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < NI; i++) begin
            sticky_m[i] = '0;
            for (int k = 0; k < 8; k++) acc_m[i][k] = 0;
        end
        was_stalled = 1'b0;
    endtask

    // One clock: drive at the falling edge, check outputs, pop/push the scoreboard.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input bit ordy, input bit clr, input bit push_clr);
        logic [EW*NI-1:0] e;
        logic [EW-1:0]    o;
        logic [EW-1:0]    x;
        bit               exp_rdy;
        @(negedge clk);
        in_valid  = v;
        a32       = a;
        b32       = b;
        c32       = c;
        out_ready = ordy;
        acc_clr   = clr;
        #1;
        if (was_stalled) check("hold_valid", def_out_valid, 1'b1);
        exp_rdy = !(exp_q.size() == 2 && !ordy);
        check("in_ready", def_in_ready, exp_rdy);
        if (def_out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", def_out_valid, 1'b0);
            end else begin
                e = exp_q[0];
                for (int i = 0; i < NI; i++) begin
                    o = obs(i);
                    x = e[i*EW +: EW];
                    check($sformatf("num%0d", i), o[255:0], x[255:0]);
                    check($sformatf("ovf%0d", i), o[263:256], x[263:256]);
                end
                if (ordy) void'(exp_q.pop_front());
            end
        end
        was_stalled = def_out_valid && !ordy;
        xfer = v && def_in_ready;
        if (xfer) push_exp(a, b, c, push_clr);
    endtask

    // Single set into an empty pipeline; returns in the cycle its result is valid.
    task automatic drive_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input bit clr_on_load);
        step(1'b1, a, b, c, 1'b1, 1'b0, clr_on_load);
        check("accept", xfer, 1'b1);
        step(1'b0, 0, 0, 0, 1'b1, clr_on_load, 1'b0);
        check("lat_1", def_out_valid, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        check("lat_2", def_out_valid, 1'b1);
    endtask

    task automatic idle_clear();
        step(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 8; k++) acc_m[i][k] = 0;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            2:       return 32'h0000_FFFF - 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sent;
        int xfers;
        rst = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        a32 = '0; b32 = '0; c32 = '0;
        model_reset();
        #1;
        check("rst_out_valid", def_out_valid, 1'b0);
        check("rst_in_ready", def_in_ready, 1'b1);
        check("rst_num", def_num, 32'h0);
        check("rst_ovf", def_ovf, 2'b00);
        check("rst_big_num", big_num, 256'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Default configuration, basic sum and difference.
        drive_one(32'h10, 32'h20, 32'h05, 1'b0);
        check("basic_num", def_num, 32'h002B_0035);
        check("basic_ovf", def_ovf, 2'b00);

        // Wrap versus saturate, overflow and underflow.
        drive_one(32'hFFFF, 32'hFFFF, 32'h1, 1'b0);
        check("wrap_ch0", def_num[15:0], 16'hFFFF);
        check("wrap_ovf0", def_ovf[0], 1'b1);
        check("sat_ch0", s4_num[15:0], 16'hFFFF);
        drive_one(32'h0, 32'h0, 32'h1, 1'b0);
        check("wrap_under", def_num[31:16], 16'hFFFF);
        check("sat_under", s4_num[31:16], 16'h0000);
        check("sat_under_ovf", s4_ovf[1], 1'b1);

        // Accumulator sequence on the mode-3 channel.
        idle_clear();
        drive_one(32'h1, 32'h1, 32'h1, 1'b0);
        check("acc_3", w4_num[63:48], 16'd3);
        drive_one(32'h1, 32'h1, 32'h1, 1'b0);
        check("acc_6", w4_num[63:48], 16'd6);
        drive_one(32'h1, 32'h1, 32'h1, 1'b0);
        check("acc_9", s4_num[63:48], 16'd9);
        drive_one(32'h2, 32'h1, 32'h1, 1'b1);
        check("acc_clr_load", w4_num[63:48], 16'd4);
        idle_clear();
        drive_one(32'h1, 32'h1, 32'h0, 1'b0);
        check("acc_clr_idle", w4_num[63:48], 16'd2);

        // Back-to-back sets with out_ready cycling 1,0,0,1.
        sent = 0;
        for (int cyc = 0; cyc < 80 && (sent < 10 || exp_q.size() > 0); cyc++) begin
            step(sent < 10, 32'(sent + 1), 32'(2 * (sent + 1)), 32'h1,
                 (cyc % 4 == 0) || (cyc % 4 == 3), 1'b0, 1'b0);
            if (xfer) sent++;
        end
        check("b2b_sent", 32'(sent), 32'd10);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Reset with both stages full and output stalled.
        step(1'b1, 32'h7, 32'h8, 32'h9, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h3, 32'h4, 32'h5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("full_before_rst", 32'(exp_q.size()), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", def_out_valid, 1'b0);
        check("midrst_num", def_num, 32'h0);
        check("midrst_ovf", def_ovf, 2'b00);
        check("midrst_big", big_num, 256'h0);
        check("midrst_ready", def_in_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive_one(32'h100, 32'h200, 32'h300, 1'b0);
        check("post_rst_num", def_num, 32'h0000_0600);

        // Random traffic against the model.
        xfers = 0;
        for (int cyc = 0; cyc < 40000 && xfers < 10000; cyc++) begin
            step($urandom_range(0, 3) != 0, rand_op(), rand_op(), rand_op(),
                 $urandom_range(0, 3) != 0, 1'b0, 1'b0);
            if (xfer) xfers++;
        end
        check("rand_xfers", 32'(xfers), 32'd10000);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        step(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        check("final_idle", def_out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
